// File: rtl/regarray_pkg.sv
// Shared definitions for the round-robin register array controller.
package regarray_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_ARB    = 2'd0;
  localparam state_t ST_ACCESS = 2'd1;
  localparam state_t ST_CLEAR  = 2'd2;

  // Address width needed to reach every word of a depth-entry array (never below one bit)
  function automatic int addr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: the first requester at or after ptr wins.
module rr_arbiter #(
  parameter int R  = 4,
  parameter int PW = (R > 1) ? $clog2(R) : 1
) (
  input  logic [R-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [R-1:0]  win,
  output logic [PW-1:0] win_idx,
  output logic          any
);

  logic [PW-1:0] cand;

  // Walk offsets from farthest to nearest so the requester closest to ptr claims the grant last
  always_comb begin
    win     = '0;
    win_idx = '0;
    cand    = '0;
    any     = |req;
    for (int k = R - 1; k >= 0; k--) begin
      cand = PW'((int'(ptr) + k) % R);
      if (req[cand]) begin
        win       = '0;
        win[cand] = 1'b1;
        win_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/regarray_arb.sv
// Register array shared by R requesters: serialised single-word access plus a word-by-word bulk clear.
module regarray_arb
  import regarray_pkg::*;
#(
  parameter int           N     = 4,
  parameter int           M     = 15,
  parameter int           R     = 4,
  parameter logic [N-1:0] VALUE = '0,
  parameter int           AW    = addr_width(M + 1)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [R-1:0]       req_i,
  input  logic [R-1:0]       we_i,
  input  logic [R*AW-1:0]    addr_i,
  input  logic [R*N-1:0]     wdata_i,
  input  logic               clr_i,
  output logic [R-1:0]       gnt_o,
  output logic [N-1:0]       rdata_o,
  output logic               rvalid_o,
  output logic               busy_o,
  output logic [(M+1)*N-1:0] array_o
);

  localparam int            PW       = (R > 1) ? $clog2(R) : 1;
  localparam logic [AW-1:0] LAST     = AW'(M);
  localparam logic [PW-1:0] LAST_REQ = PW'(R - 1);

  state_t        state;
  logic [PW-1:0] ptr;
  logic [PW-1:0] win_q;
  logic          clr_pend;
  logic [AW-1:0] idx;
  logic [N-1:0]  mem [0:M];

  logic [R-1:0]  arb_win;
  logic [PW-1:0] arb_idx;
  logic          arb_any;

  logic          acc_we;
  logic [AW-1:0] acc_addr;
  logic [N-1:0]  acc_wdata;
  logic          acc_ok;

  rr_arbiter #(
    .R  (R),
    .PW (PW)
  ) u_arb (
    .req     (req_i),
    .ptr     (ptr),
    .win     (arb_win),
    .win_idx (arb_idx),
    .any     (arb_any)
  );

  // Route the latched winner's request fields to the single access port and flag addresses past the last word
  always_comb begin
    acc_we    = 1'b0;
    acc_addr  = '0;
    acc_wdata = '0;
    for (int j = 0; j < R; j++) begin
      if (win_q == PW'(j)) begin
        acc_we    = we_i[j];
        acc_addr  = addr_i[j*AW +: AW];
        acc_wdata = wdata_i[j*N +: N];
      end
    end
    acc_ok = (acc_addr <= LAST);
  end

  // Controller state, storage, pointer, pending clear and the registered grant/read outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= ST_ARB;
      ptr      <= '0;
      win_q    <= '0;
      clr_pend <= 1'b0;
      idx      <= '0;
      gnt_o    <= '0;
      rdata_o  <= '0;
      rvalid_o <= 1'b0;
      busy_o   <= 1'b0;
      for (int i = 0; i <= M; i++) begin
        mem[i] <= VALUE;
      end
    end else begin
      gnt_o    <= '0;
      rvalid_o <= 1'b0;
      case (state)
        ST_ARB: begin
          if (clr_i || clr_pend) begin
            state    <= ST_CLEAR;
            idx      <= '0;
            clr_pend <= 1'b0;
            busy_o   <= 1'b1;
          end else if (arb_any) begin
            gnt_o  <= arb_win;
            win_q  <= arb_idx;
            state  <= ST_ACCESS;
            busy_o <= 1'b1;
          end else begin
            busy_o <= 1'b0;
          end
        end
        ST_ACCESS: begin
          if (clr_i) begin
            clr_pend <= 1'b1;
          end
          if (acc_we) begin
            if (acc_ok) begin
              mem[acc_addr] <= acc_wdata;
            end
          end else begin
            rdata_o  <= acc_ok ? mem[acc_addr] : VALUE;
            rvalid_o <= 1'b1;
          end
          ptr    <= (win_q == LAST_REQ) ? '0 : win_q + PW'(1);
          state  <= ST_ARB;
          busy_o <= 1'b0;
        end
        ST_CLEAR: begin
          if (clr_i) begin
            clr_pend <= 1'b1;
          end
          mem[idx] <= VALUE;
          if (idx == LAST) begin
            state  <= ST_ARB;
            busy_o <= 1'b0;
          end else begin
            idx    <= idx + AW'(1);
            busy_o <= 1'b1;
          end
        end
        default: begin
          state  <= ST_ARB;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

  // Expose every stored word side by side, word 0 in the low bits
  for (genvar g = 0; g <= M; g++) begin : g_flat
    assign array_o[g*N +: N] = mem[g];
  end

endmodule
